// File: rtl/zigbee_pad_pkg.sv
// zigbee_pad_pkg: capture FSM state type and default pad/channel widths for the pad multiplexer
package zigbee_pad_pkg;
  localparam int ZB_PAD_IN_W  = 22;
  localparam int ZB_PAD_OUT_W = 18;
  localparam int ZB_N_CH      = 4;
  typedef enum logic [1:0] {IDLE, CAPT, HOLD} zb_cap_state_e;
endpackage

// File: rtl/zigbee_pad_sync.sv
// zigbee_pad_sync: W-bit wide, STAGES-deep flop chain bringing asynchronous pad signals into the clock domain
module zigbee_pad_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [STAGES*W-1:0] r_ff;
  // shift the sampled pad value one stage per clock; the oldest stage is the synced output
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ff <= '0;
    else r_ff <= {r_ff[(STAGES-1)*W-1:0], i_d};
  assign o_q = r_ff[STAGES*W-1 -: W];
endmodule

// File: rtl/zigbee_pad_mux.sv
// zigbee_pad_mux: pad-side time multiplexer; defining ZIGBEE_PAD_MUX_LOOPBACK_EN adds lpbk_i to loop captured words back to the pads
module zigbee_pad_mux
  import zigbee_pad_pkg::*;
#(
  parameter  int PAD_IN_W    = ZB_PAD_IN_W,
  parameter  int PAD_OUT_W   = ZB_PAD_OUT_W,
  parameter  int N_CH        = ZB_N_CH,
  parameter  int SYNC_STAGES = 2,
  parameter  int SEL_STABLE  = 2,
  localparam int SEL_W       = $clog2(N_CH)
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  input  logic [SEL_W-1:0]          pad_sel_i,
  input  logic                      pad_stb_i,
  input  logic [PAD_IN_W-1:0]       pad_in_i,
  output logic [PAD_OUT_W-1:0]      pad_out_o,
  output logic [N_CH*PAD_IN_W-1:0]  core_in_o,
  output logic [N_CH-1:0]           core_in_vld_o,
  input  logic [N_CH-1:0]           core_in_ack_i,
  input  logic [N_CH*PAD_OUT_W-1:0] core_out_i,
  output logic [N_CH-1:0]           ovr_o,
  output logic                      err_o
`ifdef ZIGBEE_PAD_MUX_LOOPBACK_EN
  ,
  input  logic                      lpbk_i
`endif
);
  localparam int              CNT_W  = $clog2(SEL_STABLE + 1);
  localparam logic [SEL_W:0]  N_CH_W = (SEL_W+1)'(N_CH);
  logic [SEL_W-1:0]          w_s_sel;
  logic                      w_s_stb;
  logic [PAD_IN_W-1:0]       w_s_in;
  logic                      w_sel_ok;
  logic                      w_capt;
  logic [N_CH-1:0]           w_hit;
  zb_cap_state_e             r_state;
  zb_cap_state_e             w_state_nxt;
  logic [N_CH*PAD_IN_W-1:0]  r_core_in;
  logic [N_CH-1:0]           r_vld;
  logic [N_CH-1:0]           r_ovr;
  logic                      r_err;
  logic [SEL_W-1:0]          r_prev_sel;
  logic [SEL_W-1:0]          r_act_sel;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W:0]            w_held;
  logic                      w_stable;
  logic [PAD_OUT_W-1:0]      w_pad_nxt;
  logic [PAD_OUT_W-1:0]      r_pad_out;

  zigbee_pad_sync #(.W(SEL_W + 1 + PAD_IN_W), .STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (clk_i),
    .i_rst_n (resetn_i),
    .i_d     ({pad_sel_i, pad_stb_i, pad_in_i}),
    .o_q     ({w_s_sel, w_s_stb, w_s_in})
  );

  // capture FSM state register
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) r_state <= IDLE;
    else r_state <= w_state_nxt;

  // next state; the capture fires on the IDLE->CAPT transition so word and vld are registered as CAPT begins
  always_comb begin
    w_state_nxt = r_state;
    w_capt      = 1'b0;
    case (r_state)
      IDLE: begin
        w_capt      = w_s_stb;
        w_state_nxt = w_s_stb ? CAPT : IDLE;
      end
      CAPT:    w_state_nxt = HOLD;
      HOLD:    w_state_nxt = w_s_stb ? HOLD : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_sel_ok = {1'b0, w_s_sel} < N_CH_W;
  assign w_hit    = (w_capt && w_sel_ok) ? N_CH'(1) << w_s_sel : '0;

  // channel words plus valid, overrun and bad-select flags; a capture beats a same-cycle ack
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) begin
      r_core_in <= '0;
      r_vld     <= '0;
      r_ovr     <= '0;
      r_err     <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (w_hit[c]) r_core_in[c*PAD_IN_W +: PAD_IN_W] <= w_s_in;
      r_vld <= w_hit | (r_vld & ~core_in_ack_i);
      r_ovr <= r_ovr | (w_hit & r_vld & ~core_in_ack_i);
      r_err <= r_err | (w_capt & ~w_sel_ok);
    end

  assign w_held   = (w_s_sel == r_prev_sel) ? {1'b0, r_cnt} + 1'b1 : (CNT_W+1)'(1);
  assign w_stable = w_held >= (CNT_W+1)'(SEL_STABLE);

  // track how long synced sel has been unchanged and adopt it once stable and in range
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) begin
      r_prev_sel <= '0;
      r_cnt      <= '0;
      r_act_sel  <= '0;
    end else begin
      r_prev_sel <= w_s_sel;
      r_cnt      <= w_stable ? CNT_W'(SEL_STABLE) : w_held[CNT_W-1:0];
      if (w_stable && w_sel_ok) r_act_sel <= w_s_sel;
    end

`ifdef ZIGBEE_PAD_MUX_LOOPBACK_EN
  logic                w_s_lpbk;
  logic [PAD_IN_W-1:0] w_lb_word;
  zigbee_pad_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_lpbk (
    .i_clk   (clk_i),
    .i_rst_n (resetn_i),
    .i_d     (lpbk_i),
    .o_q     (w_s_lpbk)
  );
  assign w_lb_word = r_core_in[int'(r_act_sel)*PAD_IN_W +: PAD_IN_W];
  assign w_pad_nxt = w_s_lpbk ? PAD_OUT_W'(w_lb_word)
                              : core_out_i[int'(r_act_sel)*PAD_OUT_W +: PAD_OUT_W];
`else
  assign w_pad_nxt = core_out_i[int'(r_act_sel)*PAD_OUT_W +: PAD_OUT_W];
`endif

  // single registered stage towards the pads
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) r_pad_out <= '0;
    else r_pad_out <= w_pad_nxt;

  assign pad_out_o     = r_pad_out;
  assign core_in_o     = r_core_in;
  assign core_in_vld_o = r_vld;
  assign ovr_o         = r_ovr;
  assign err_o         = r_err;
endmodule

// File: tb/tb_zigbee_pad_mux.sv
// tb_zigbee_pad_mux: directed and randomized checks of capture, handshake, output mux and reset against a behavioural model
module tb_zigbee_pad_mux;
  localparam int IW = 22, OW = 18, SY = 2, SS = 2;
  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [1:0]      pad_sel = '0;
  logic            pad_stb = 1'b0;
  logic [IW-1:0]   pad_in = '0;
  logic [3:0]      ack = '0;
  logic [4*OW-1:0] core_out = '0;
  logic [OW-1:0]   pad_out, pad_out3;
  logic [4*IW-1:0] core_in;
  logic [3*IW-1:0] core_in3;
  logic [3:0]      vld, ovr;
  logic [2:0]      vld3, ovr3;
  logic            err, err3;
`ifdef ZIGBEE_PAD_MUX_LOOPBACK_EN
  logic            lpbk = 1'b0;
`endif
  int n_tests = 0;
  int n_fail = 0;
  logic [IW-1:0] m_word [2][4];
  logic [3:0]    m_vld [2];
  logic [3:0]    m_ovr [2];
  logic          m_err [2];
  int            m_act3;

  always #5 clk = ~clk;

  zigbee_pad_mux #(.PAD_IN_W(IW), .PAD_OUT_W(OW), .N_CH(4), .SYNC_STAGES(SY), .SEL_STABLE(SS)) dut (
    .clk_i(clk), .resetn_i(resetn), .pad_sel_i(pad_sel), .pad_stb_i(pad_stb), .pad_in_i(pad_in),
    .pad_out_o(pad_out), .core_in_o(core_in), .core_in_vld_o(vld), .core_in_ack_i(ack),
    .core_out_i(core_out), .ovr_o(ovr), .err_o(err)
`ifdef ZIGBEE_PAD_MUX_LOOPBACK_EN
    , .lpbk_i(lpbk)
`endif
  );

  zigbee_pad_mux #(.PAD_IN_W(IW), .PAD_OUT_W(OW), .N_CH(3), .SYNC_STAGES(SY), .SEL_STABLE(SS)) dut3 (
    .clk_i(clk), .resetn_i(resetn), .pad_sel_i(pad_sel), .pad_stb_i(pad_stb), .pad_in_i(pad_in),
    .pad_out_o(pad_out3), .core_in_o(core_in3), .core_in_vld_o(vld3), .core_in_ack_i(3'b000),
    .core_out_i(core_out[3*OW-1:0]), .ovr_o(ovr3), .err_o(err3)
`ifdef ZIGBEE_PAD_MUX_LOOPBACK_EN
    , .lpbk_i(lpbk)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pk(input int k);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[c*IW +: IW] = m_word[k][c];
    return r;
  endfunction

  function automatic void m_clear();
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = '0;
      m_ovr[k] = '0;
      m_err[k] = 1'b0;
      for (int c = 0; c < 4; c++) m_word[k][c] = '0;
    end
    m_act3 = 0;
  endfunction

  // capture into instance k (4 and 3 channels); only the 4-channel instance gets acks
  function automatic void m_cap(input int sel, input logic [IW-1:0] d, input logic [3:0] a);
    logic [3:0] ak;
    int nch;
    for (int k = 0; k < 2; k++) begin
      ak  = (k == 0) ? a : 4'b0000;
      nch = (k == 0) ? 4 : 3;
      if (sel >= nch) begin
        m_vld[k] = m_vld[k] & ~ak;
        m_err[k] = 1'b1;
      end else begin
        if (m_vld[k][sel] && !ak[sel]) m_ovr[k][sel] = 1'b1;
        m_vld[k] = m_vld[k] & ~ak;
        m_vld[k][sel] = 1'b1;
        m_word[k][sel] = d;
      end
    end
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".vld"},   128'(vld),      128'(m_vld[0]));
    chk({tag, ".vld3"},  128'(vld3),     128'(m_vld[1][2:0]));
    chk({tag, ".word"},  128'(core_in),  pk(0));
    chk({tag, ".word3"}, 128'(core_in3), pk(1));
    chk({tag, ".ovr"},   128'(ovr),      128'(m_ovr[0]));
    chk({tag, ".ovr3"},  128'(ovr3),     128'(m_ovr[1][2:0]));
    chk({tag, ".err"},   128'(err),      128'(m_err[0]));
    chk({tag, ".err3"},  128'(err3),     128'(m_err[1]));
  endtask

  task automatic chk_pad(input string tag);
    int s;
    s = int'(pad_sel);
    chk({tag, ".pad"},  128'(pad_out),  128'(core_out[s*OW +: OW]));
    chk({tag, ".pad3"}, 128'(pad_out3), 128'(core_out[m_act3*OW +: OW]));
  endtask

  // strobe high for SY+1+extra cycles; ack vector a is sampled on the capture edge
  task automatic strobe(input string tag, input logic [1:0] sel, input logic [IW-1:0] d,
                        input int extra, input logic [3:0] a);
    pad_sel = sel;
    pad_in  = d;
    pad_stb = 1'b1;
    repeat (SY) tick;
    chk({tag, ".pre"}, 128'(vld), 128'(m_vld[0]));
    ack = a;
    tick;
    ack = '0;
    m_cap(int'(sel), d, a);
    chk_all(tag);
    repeat (extra) tick;
    pad_stb = 1'b0;
    repeat (SY + 2) tick;
    chk({tag, ".once"},  128'(ovr),  128'(m_ovr[0]));
    chk({tag, ".once3"}, 128'(ovr3), 128'(m_ovr[1][2:0]));
    if (sel < 2'd3) m_act3 = int'(sel);
  endtask

  task automatic do_ack(input string tag, input logic [3:0] a);
    ack = a;
    chk({tag, ".pre"}, 128'(vld), 128'(m_vld[0]));
    tick;
    ack = '0;
    m_vld[0] = m_vld[0] & ~a;
    chk({tag, ".post"}, 128'(vld), 128'(m_vld[0]));
  endtask

  task automatic do_reset;
    pad_stb = 1'b0;
    pad_sel = '0;
    ack     = '0;
    resetn  = 1'b0;
    #2;
    m_clear();
    tick;
    resetn = 1'b1;
    repeat (SY + 3) tick;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_clear();
    #12;
    chk_all("rst");
    chk("rst.pad",  128'(pad_out),  128'(0));
    chk("rst.pad3", 128'(pad_out3), 128'(0));
    tick;
    resetn = 1'b1;
    repeat (4) tick;
    // T1: four-cycle strobe into ch2, one capture
    strobe("t1", 2'd2, 22'h2A5A5A, 1, 4'b0000);
    chk("t1.vldc", 128'(vld), 128'(4'b0100));
    // T2: overwrite ch1 without ack, then ack clears one cycle later
    strobe("t2a", 2'd1, 22'h155555, 0, 4'b0000);
    strobe("t2b", 2'd1, 22'h000001, 2, 4'b0000);
    chk("t2.ovr", 128'(ovr), 128'(4'b0010));
    do_ack("t2.ack", 4'b0010);
    // T3: ack on the capture edge of ch3
    strobe("t3a", 2'd3, 22'h0ABCDE, 0, 4'b0000);
    strobe("t3b", 2'd3, 22'h3F0F0F, 0, 4'b1000);
    chk("t3.vld3", 128'(vld[3]), 128'(1'b1));
    chk("t3.ovr3", 128'(ovr[3]), 128'(1'b0));
    // T4: output mux latency and glitch filter
    do_reset();
    core_out = {18'h3FFFF, 18'h2AAAA, 18'h15555, 18'h00001};
    repeat (6) tick;
    chk("t4.ch0", 128'(pad_out), 128'(18'h00001));
    pad_sel = 2'd3;
    repeat (SY + SS) tick;
    chk("t4.hold", 128'(pad_out), 128'(18'h00001));
    tick;
    chk("t4.sw", 128'(pad_out), 128'(18'h3FFFF));
    chk("t4.n3", 128'(pad_out3), 128'(18'h00001));
    pad_sel = 2'd0;
    repeat (6) tick;
    chk("t4.back", 128'(pad_out), 128'(18'h00001));
    pad_sel = 2'd3;
    tick;
    pad_sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("t4.glitch", 128'(pad_out), 128'(18'h00001));
    end
    // T5: select beyond channel count on the 3-channel instance
    do_reset();
    strobe("t5a", 2'd0, 22'h3C3C3C, 0, 4'b0000);
    chk("t5.err0", 128'(err3), 128'(1'b0));
    strobe("t5b", 2'd3, 22'h111111, 0, 4'b0000);
    chk("t5.err", 128'(err3), 128'(1'b1));
    chk("t5.vld", 128'(vld3), 128'(3'b001));
    chk("t5.word", 128'(core_in3), 128'(66'h3C3C3C));
    // T6: reset during CAPT, strobe still high at release
    do_reset();
    pad_sel = 2'd2;
    pad_in  = 22'h12345;
    pad_stb = 1'b1;
    repeat (SY + 1) tick;
    chk("t6.capt", 128'(vld), 128'(4'b0100));
    #1;
    resetn = 1'b0;
    #1;
    m_clear();
    chk_all("t6.rst");
    chk("t6.pad", 128'(pad_out), 128'(0));
    pad_in = 22'h2C0FFE;
    tick;
    tick;
    resetn = 1'b1;
    repeat (SY) tick;
    chk("t6.pre", 128'(vld), 128'(4'b0000));
    tick;
    m_cap(2, 22'h2C0FFE, 4'b0000);
    chk_all("t6.cap");
    pad_stb = 1'b0;
    repeat (SY + 2) tick;
    chk("t6.once", 128'(ovr), 128'(4'b0000));
    m_act3 = 2;
`ifdef ZIGBEE_PAD_MUX_LOOPBACK_EN
    lpbk = 1'b1;
    repeat (SY + 2) tick;
    chk("t6.lpbk",  128'(pad_out),  128'(18'h00FFE));
    chk("t6.lpbk3", 128'(pad_out3), 128'(18'h00FFE));
    lpbk = 1'b0;
    repeat (SY + 2) tick;
`endif
    // randomized traffic
    do_reset();
    for (int i = 0; i < 40; i++) begin
      core_out = {8'($urandom), 32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) do_ack("rnd.ack", 4'($urandom));
      else strobe("rnd", 2'($urandom), IW'($urandom), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
      tick;
      chk_pad("rnd");
    end
    chk_all("end");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
